// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: full-speed USB TX line stage. A fractional bit
// timer (8,8,9 clocks) paces an LSB-first shifter with bit stuffing
// and NRZI, driving D+/D- including SE0 for EOP.
// Ports: clk, rst (async, high), enable_timer, clear_timer,
//   load_enable, data_pts[7:0], state_val[2:0] in;
//   shift_strobe, flag, dplus, dminus out.
// Build option: define TX_STUFF_CNT_EN to add stuff_count[7:0],
//   a saturating count of inserted stuff bits.
module usb_tx_serializer #(
    parameter int BASE_CLKS  = 8,
    parameter int LONG_EVERY = 3,
    parameter int STUFF_LEN  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_timer,
    input  logic       clear_timer,
    input  logic       load_enable,
    input  logic [7:0] data_pts,
    input  logic [2:0] state_val,
    output logic       shift_strobe,
    output logic       flag,
    output logic       dplus,
    output logic       dminus
`ifdef TX_STUFF_CNT_EN
    ,
    output logic [7:0] stuff_count
`endif
);

    localparam int CW = $clog2(BASE_CLKS + 1);
    localparam int PW = (LONG_EVERY > 1) ? $clog2(LONG_EVERY) : 1;
    localparam int OW = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {
        IDLE_J,
        DATA,
        STUFF,
        SE0
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [PW-1:0] phase;
    logic [2:0]    bit_cnt;
    logic [OW-1:0] ones;
    logic [7:0]    sr;
    logic          level;

    logic          long_bit;
    logic [CW-1:0] last;
    logic          period_end;
    logic          is_idle;
    logic          is_se0;
    logic          hold_line;
    logic          cur_bit;
    logic          next_level;
    logic [OW-1:0] ones_inc;

    assign long_bit   = (phase == PW'(LONG_EVERY - 1));
    assign last       = long_bit ? CW'(BASE_CLKS) : CW'(BASE_CLKS - 1);
    assign period_end = enable_timer && !clear_timer && (count == last);

    // Idle and SE0 force the line at once; data states wait for a
    // period boundary.
    assign is_idle   = (state_val == 3'd0);
    assign is_se0    = (state_val[2:1] == 2'b11);
    assign hold_line = is_idle || is_se0;

    // NRZI: a 0 toggles the line level, a 1 keeps it.
    assign cur_bit    = sr[0];
    assign next_level = cur_bit ? level : ~level;
    assign ones_inc   = ones + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE_J;
            count        <= '0;
            phase        <= '0;
            bit_cnt      <= '0;
            ones         <= '0;
            sr           <= '0;
            level        <= 1'b1;
            shift_strobe <= 1'b0;
            flag         <= 1'b0;
            dplus        <= 1'b1;
            dminus       <= 1'b0;
`ifdef TX_STUFF_CNT_EN
            stuff_count  <= '0;
`endif
        end else begin
            shift_strobe <= 1'b0;
            flag         <= 1'b0;

            if (period_end) begin
                count <= '0;
                phase <= long_bit ? '0 : phase + 1'b1;
            end else if (enable_timer && !clear_timer) begin
                count <= count + 1'b1;
            end

            if (hold_line) begin
                // The TX FSM still waits on strobes during EOP/idle.
                state        <= is_idle ? IDLE_J : SE0;
                level        <= 1'b1;
                ones         <= '0;
                dplus        <= is_idle;
                dminus       <= 1'b0;
                shift_strobe <= period_end;
            end else if (period_end) begin
                if (state == STUFF) begin
                    // Stuffed 0: toggle only, data path stalls.
                    level  <= ~level;
                    dplus  <= ~level;
                    dminus <= level;
                    ones   <= '0;
                    state  <= DATA;
`ifdef TX_STUFF_CNT_EN
                    if (stuff_count != 8'hFF)
                        stuff_count <= stuff_count + 8'd1;
`endif
                end else begin
                    level        <= next_level;
                    dplus        <= next_level;
                    dminus       <= ~next_level;
                    shift_strobe <= 1'b1;
                    sr           <= {1'b0, sr[7:1]};
                    bit_cnt      <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        flag <= 1'b1;
                    if (cur_bit) begin
                        ones  <= ones_inc;
                        state <= (ones_inc == OW'(STUFF_LEN)) ? STUFF : DATA;
                    end else begin
                        ones  <= '0;
                        state <= DATA;
                    end
                end
            end

            // A fresh byte overrides the shift of the same cycle.
            if (load_enable) begin
                sr      <= data_pts;
                bit_cnt <= '0;
            end

            if (clear_timer) begin
                count   <= '0;
                phase   <= '0;
                bit_cnt <= '0;
                ones    <= '0;
                if (!hold_line && state == STUFF)
                    state <= DATA;
`ifdef TX_STUFF_CNT_EN
                stuff_count <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer: scoreboard bench for usb_tx_serializer.
// Expected line events are queued by stimulus and popped by a monitor.
module tb_usb_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable_timer = 1'b0;
    logic       clear_timer = 1'b0;
    logic       load_enable = 1'b0;
    logic [7:0] data_pts = 8'h00;
    logic [2:0] state_val = 3'd0;
    logic       shift_strobe;
    logic       flag;
    logic       dplus;
    logic       dminus;
`ifdef TX_STUFF_CNT_EN
    logic [7:0] stuff_count;
`endif

    usb_tx_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .enable_timer (enable_timer),
        .clear_timer  (clear_timer),
        .load_enable  (load_enable),
        .data_pts     (data_pts),
        .state_val    (state_val),
        .shift_strobe (shift_strobe),
        .flag         (flag),
        .dplus        (dplus),
        .dminus       (dminus)
`ifdef TX_STUFF_CNT_EN
        ,
        .stuff_count  (stuff_count)
`endif
    );

    always #5 clk = ~clk;

    // bits = {strobe, flag, dplus, dminus}; gap 0 = not checked
    typedef struct packed {
        logic [3:0] bits;
        logic [7:0] gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ev_idx = 0;

    localparam logic [3:0] S_J   = 4'b1010;
    localparam logic [3:0] S_K   = 4'b1001;
    localparam logic [3:0] F_J   = 4'b1110;
    localparam logic [3:0] F_K   = 4'b1101;
    localparam logic [3:0] L_J   = 4'b0010;
    localparam logic [3:0] L_K   = 4'b0001;
    localparam logic [3:0] L_SE0 = 4'b0000;
    localparam logic [3:0] S_SE0 = 4'b1000;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] b, input int g);
        exp_t e;
        e.bits = b;
        e.gap  = 8'(g);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: %0d events pending, required 0",
                     tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic first_strobe(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!shift_strobe && n < 40);
        check(tag, 32'(n), 32'd8);
    endtask

    // Monitor: an event is a strobe or any change of the line pair.
    int         gap_cnt = 0;
    logic [1:0] prev_line = 2'b10;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst) begin
            gap_cnt   = 0;
            prev_line = {dplus, dminus};
        end else begin
            gap_cnt++;
            if (shift_strobe || ({dplus, dminus} != prev_line)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got %b%b%b%b, required none",
                             shift_strobe, flag, dplus, dminus);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("event%0d", ev_idx),
                          32'({shift_strobe, flag, dplus, dminus}),
                          32'(mon_e.bits));
                    if (mon_e.gap != 8'd0)
                        check($sformatf("gap%0d", ev_idx),
                              32'(gap_cnt), 32'(mon_e.gap));
                end
                ev_idx++;
                gap_cnt = 0;
            end
            prev_line = {dplus, dminus};
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_out", 32'({dplus, dminus, shift_strobe, flag}),
              32'(4'b1000));
`ifdef TX_STUFF_CNT_EN
        check("rst_stuff_count", 32'(stuff_count), 32'd0);
`endif
        rst = 1'b0;
        clear_timer = 1'b1;
        tick();

        // Timer spacing in idle: 8,8,9,8,8,9
        clear_timer = 1'b0;
        push(S_J, 0);
        push(S_J, 8);
        push(S_J, 9);
        push(S_J, 8);
        push(S_J, 8);
        push(S_J, 9);
        enable_timer = 1'b1;
        first_strobe("timer_first");
        wait_empty("timer", 200);

        // Sync byte 0x80 from J
        push(S_K, 0);
        push(S_J, 0);
        push(S_K, 0);
        push(S_J, 0);
        push(S_K, 0);
        push(S_J, 0);
        push(S_K, 0);
        push(F_K, 0);
        load_enable = 1'b1;
        data_pts = 8'h80;
        state_val = 3'd2;
        tick();
        load_enable = 1'b0;
        wait_empty("sync", 200);

        // Back to J, stop and clear the timer
        push(L_J, 0);
        state_val = 3'd0;
        enable_timer = 1'b0;
        clear_timer = 1'b1;
        tick();
        clear_timer = 1'b0;
        load_enable = 1'b1;
        data_pts = 8'hFF;
        state_val = 3'd3;
        tick();
        load_enable = 1'b0;

        // 0xFF: six J bits, stuff to K, two K bits
        repeat (6) push(S_J, 0);
        push(L_K, 0);
        push(S_K, 0);
        push(F_K, 0);
        enable_timer = 1'b1;
        wait_empty("stuff", 200);
`ifdef TX_STUFF_CNT_EN
        check("stuff_count1", 32'(stuff_count), 32'd1);
`endif

        // Second 0xFF: ones carry over, stuff after 4th bit
        repeat (4) push(S_K, 0);
        push(L_J, 0);
        repeat (3) push(S_J, 0);
        push(F_J, 0);
        load_enable = 1'b1;
        tick();
        load_enable = 1'b0;
        wait_empty("stuff2", 200);
`ifdef TX_STUFF_CNT_EN
        check("stuff_count2", 32'(stuff_count), 32'd2);
`endif

        // EOP: SE0 at once, strobes continue, then J
        push(L_SE0, 0);
        push(S_SE0, 0);
        state_val = 3'd6;
        wait_empty("eop6", 200);
        push(S_SE0, 0);
        state_val = 3'd7;
        wait_empty("eop7", 200);
        push(L_J, 0);
        push(S_J, 0);
        state_val = 3'd0;
        wait_empty("eop_idle", 200);

        // Reset mid-byte on 0x00 while line is K
        push(S_K, 0);
        push(S_J, 0);
        push(S_K, 0);
        load_enable = 1'b1;
        data_pts = 8'h00;
        state_val = 3'd1;
        tick();
        load_enable = 1'b0;
        wait_empty("zero", 200);
        repeat (4) tick();
        state_val = 3'd0;
        rst = 1'b1;
        #1;
        check("rst_mid", 32'({dplus, dminus, shift_strobe, flag}),
              32'(4'b1000));
        tick();
        tick();
        rst = 1'b0;
        enable_timer = 1'b0;
        clear_timer = 1'b1;
        tick();
        clear_timer = 1'b0;
        push(S_J, 0);
        enable_timer = 1'b1;
        first_strobe("rst_first");
        enable_timer = 1'b0;
        wait_empty("rst_tail", 50);
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
